// File: rtl/lfsr_checker.sv
// Receive-side checker for the Galois LFSR pattern generator: self-synchronises to
// the incoming state-word sequence, declares lock, then flags and counts mismatches.
module lfsr_checker #(
    parameter int                 WIDTH    = 4,
    parameter logic [WIDTH-1:0]   TAPS     = 4'b0111,
    parameter int                 LOCK_CNT = 4,
    parameter int                 LOSS_CNT = 3,
    parameter int                 CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int MAX_CNT = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0]    LOCK_C   = CW'(LOCK_CNT);
    localparam logic [CW-1:0]    LOSS_C   = CW'(LOSS_CNT);
    localparam logic [CW-1:0]    ONE_C    = CW'(1);
    localparam logic [CW-1:0]    ZERO_C   = CW'(0);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             seed_q, seed_d;
    logic [CW-1:0]    match_q, match_d;
    logic [CW-1:0]    miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_base_s;
    logic             miss_beat_s;
    logic             hit_s;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] q);
        lfsr_next = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? TAPS : ZERO_W);
    endfunction

    // Next-state logic for the search/lock predictor and the mismatch pulse
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        seed_d      = seed_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_d       = 1'b0;
        miss_beat_s = 1'b0;
        // The all-zero word is the LFSR lock-up state, so it can never count as a hit.
        hit_s       = seed_q && (data_i == exp_q) && (data_i != ZERO_W);
        if (valid_i) begin
            case (state_q)
                ST_SEARCH: begin
                    exp_d  = lfsr_next(data_i);
                    seed_d = (data_i != ZERO_W);
                    if (hit_s) begin
                        if ((match_q + ONE_C) == LOCK_C) begin
                            state_d = ST_LOCKED;
                            match_d = ZERO_C;
                            miss_d  = ZERO_C;
                        end else begin
                            match_d = match_q + ONE_C;
                        end
                    end else begin
                        match_d = ZERO_C;
                    end
                end
                ST_LOCKED: begin
                    exp_d = lfsr_next(exp_q);
                    if (data_i == exp_q) begin
                        miss_d = ZERO_C;
                    end else begin
                        err_d       = 1'b1;
                        miss_beat_s = 1'b1;
                        if ((miss_q + ONE_C) == LOSS_C) begin
                            state_d = ST_SEARCH;
                            seed_d  = 1'b0;
                            match_d = ZERO_C;
                            miss_d  = ZERO_C;
                        end else begin
                            miss_d = miss_q + ONE_C;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    seed_d  = 1'b0;
                    match_d = ZERO_C;
                    miss_d  = ZERO_C;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // Error counter: clear takes effect first, then a same-cycle mismatch is counted
    always_comb begin
        cnt_base_s = clear_i ? CNT_ZERO : cnt_q;
        if (miss_beat_s && (cnt_base_s != CNT_SAT)) begin
            cnt_d = cnt_base_s + CNT_ONE;
        end else begin
            cnt_d = cnt_base_s;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_SEARCH;
            exp_q    <= ZERO_W;
            seed_q   <= 1'b0;
            match_q  <= ZERO_C;
            miss_q   <= ZERO_C;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= CNT_ZERO;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            seed_q   <= seed_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised and directed bench for lfsr_checker: three parameterisations share one
// stimulus stream and are compared against a behavioural sequence model.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        valid_i;
    logic [3:0]  data_i;

    logic        locked0, locked1, locked2;
    logic        err0, err1, err2;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    int total = 0;
    int bad   = 0;

    // model parameters per instance: default, LOCK_CNT=2, CNT_W=2/LOSS_CNT=255
    int lockc[3] = '{4, 2, 4};
    int lossc[3] = '{3, 3, 255};
    int cmax[3]  = '{65535, 65535, 3};

    bit m_locked[3];
    bit m_seed[3];
    int m_pred[3];
    int m_streak[3];
    int m_miss[3];
    int m_err[3];
    int m_cnt[3];

    always #5 clk = ~clk;

    lfsr_checker dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
        .data_i(data_i), .locked_o(locked0), .err_o(err0), .err_cnt_o(cnt0)
    );

    lfsr_checker #(.LOCK_CNT(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
        .data_i(data_i), .locked_o(locked1), .err_o(err1), .err_cnt_o(cnt1)
    );

    lfsr_checker #(.CNT_W(2), .LOSS_CNT(255)) dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
        .data_i(data_i), .locked_o(locked2), .err_o(err2), .err_cnt_o(cnt2)
    );

    // successor in GF(2) arithmetic: multiply by x modulo x^4+x^2+x+1 pattern
    function automatic int nx(input int q);
        int r;
        r = (q * 2) % 16;
        if (q >= 8) r = r ^ 7;
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        if (obs != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_locked[k] = 1'b0; m_seed[k] = 1'b0; m_pred[k] = 0;
            m_streak[k] = 0; m_miss[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_step(input bit v, input int d, input bit c);
        bit wrong;
        for (int k = 0; k < 3; k++) begin
            wrong = 1'b0;
            m_err[k] = 0;
            if (v && !m_locked[k]) begin
                if (m_seed[k] && d == m_pred[k] && d != 0) m_streak[k]++;
                else m_streak[k] = 0;
                m_pred[k] = nx(d);
                m_seed[k] = (d != 0);
                if (m_streak[k] == lockc[k]) begin
                    m_locked[k] = 1'b1; m_streak[k] = 0; m_miss[k] = 0;
                end
            end else if (v) begin
                wrong = (d != m_pred[k]);
                m_pred[k] = nx(m_pred[k]);
                if (wrong) begin
                    m_err[k] = 1;
                    m_miss[k]++;
                    if (m_miss[k] == lossc[k]) begin
                        m_locked[k] = 1'b0; m_seed[k] = 1'b0; m_streak[k] = 0; m_miss[k] = 0;
                    end
                end else begin
                    m_miss[k] = 0;
                end
            end
            if (c) m_cnt[k] = 0;
            if (wrong && m_cnt[k] < cmax[k]) m_cnt[k]++;
        end
    endtask

    task automatic check_all();
        chk("locked0", int'(locked0), int'(m_locked[0]));
        chk("locked1", int'(locked1), int'(m_locked[1]));
        chk("locked2", int'(locked2), int'(m_locked[2]));
        chk("err0", int'(err0), m_err[0]);
        chk("err1", int'(err1), m_err[1]);
        chk("err2", int'(err2), m_err[2]);
        chk("cnt0", int'(cnt0), m_cnt[0]);
        chk("cnt1", int'(cnt1), m_cnt[1]);
        chk("cnt2", int'(cnt2), m_cnt[2]);
    endtask

    task automatic step(input bit v, input int d, input bit c);
        @(negedge clk);
        valid_i = v;
        data_i  = 4'(d);
        clear_i = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        clear_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        int gen;
        int r;
        bit v;
        bit c;
        int d;

        rst_ni  = 1'b0;
        clear_i = 1'b0;
        valid_i = 1'b0;
        data_i  = 4'b0000;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_ni = 1'b1;

        // idle after reset
        for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b0);

        // acquire: LOCK_CNT=2 locks after 0101, default after 0011
        step(1'b1, 15, 1'b0);
        step(1'b1, 9, 1'b0);
        step(1'b1, 5, 1'b0);
        chk("lock2_after_0101", int'(locked1), 1);
        chk("nolock4_after_0101", int'(locked0), 0);
        step(1'b1, 10, 1'b0);
        step(1'b1, 3, 1'b0);
        chk("lock4_after_0011", int'(locked0), 1);
        chk("cnt_zero_at_lock", int'(cnt0), 0);

        // single corrupted beat (0111 instead of 0110), then resume 1100
        step(1'b1, 7, 1'b0);
        chk("err_pulse", int'(err0), 1);
        chk("cnt_one", int'(cnt0), 1);
        step(1'b1, 12, 1'b0);
        chk("err_clears", int'(err0), 0);
        chk("still_locked", int'(locked0), 1);

        // three all-zero beats lose lock at LOSS_CNT=3
        step(1'b1, 0, 1'b0);
        step(1'b1, 0, 1'b0);
        chk("locked_before_loss", int'(locked0), 1);
        step(1'b1, 0, 1'b0);
        chk("lost_lock", int'(locked0), 0);
        chk("loss_beat_flagged", int'(err0), 1);
        chk("cnt_after_loss", int'(cnt0), 4);
        chk("cnt2_saturated", int'(cnt2), 3);

        // relock from 1111 after LOCK_CNT+1 beats
        step(1'b1, 15, 1'b0);
        step(1'b1, 9, 1'b0);
        step(1'b1, 5, 1'b0);
        step(1'b1, 10, 1'b0);
        chk("not_yet_relocked", int'(locked0), 0);
        step(1'b1, 3, 1'b0);
        chk("relocked", int'(locked0), 1);

        // clear coinciding with a mismatch leaves the count at 1
        step(1'b1, 0, 1'b0);
        chk("cnt_five", int'(cnt0), 5);
        step(1'b1, 0, 1'b1);
        chk("clear_then_count", int'(cnt0), 1);
        step(1'b1, 15, 1'b0);
        step(1'b0, 0, 1'b1);
        chk("clear_idle", int'(cnt0), 0);

        // all-zero words in SEARCH never seed or lock
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b0);
        chk("zeros_no_lock", int'(locked1), 0);
        step(1'b1, 15, 1'b0);
        step(1'b1, 9, 1'b0);
        chk("one_hit_only", int'(locked1), 0);
        step(1'b1, 5, 1'b0);
        chk("lock2_after_zeros", int'(locked1), 1);
        step(1'b1, 10, 1'b0);
        step(1'b1, 3, 1'b0);
        chk("locked_before_async", int'(locked0), 1);

        // asynchronous reset between clock edges
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_locked0", int'(locked0), 0);
        chk("async_locked1", int'(locked1), 0);
        chk("async_cnt0", int'(cnt0), 0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;

        // randomised run: mostly-correct sequence with injected faults and restarts
        gen = 1 + int'($urandom_range(14));
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(40) == 0);
            d = 0;
            if (v) begin
                r = int'($urandom_range(19));
                if (r == 0) d = int'($urandom_range(15));
                else if (r == 1) d = 0;
                else if (r == 2) begin
                    gen = 1 + int'($urandom_range(14));
                    d = gen;
                end else d = gen;
                gen = nx(gen);
            end
            step(v, d, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
